// File: rtl/fwft_rx_deframer_pkg.sv
// Shared definitions for the FWFT receive deframer.
// State encoding and header field positions.
package fwft_rx_deframer_pkg;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    localparam int LEN_LSB = 0;
    localparam int TAG_LSB = 16;
    localparam int TAG_W   = 16;

endpackage

// File: rtl/fwft_out_reg.sv
// Single-entry valid/ready output register.
// A load replaces the held word even when it is accepted in the same cycle.
module fwft_out_reg
    import fwft_rx_deframer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_sof,
    input  logic              ld_eof,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_sof,
    output logic              m_eof
);

    // Load a new word, otherwise drop valid once the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (load) begin
            m_data  <= ld_data;
            m_valid <= 1'b1;
            m_sof   <= ld_sof;
            m_eof   <= ld_eof;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fwft_rx_deframer.sv
// Header parser on the read side of an FWFT FIFO.
// Emits framed payload, drops oversize packets, counts legal headers.
module fwft_rx_deframer
    import fwft_rx_deframer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int MAX_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eof,
    output logic [15:0]       m_tag,
    output logic              pkt_err,
    output logic [31:0]       pkt_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   rem;
    logic               first;
    logic               pop;
    logic               load;
    logic               last;
    logic               oversize;
    logic [LEN_W-1:0]   hdr_len;
    logic [TAG_W-1:0]   hdr_tag;

    assign hdr_len  = fifo_dout[LEN_LSB +: LEN_W];
    assign hdr_tag  = fifo_dout[TAG_LSB +: TAG_W];
    assign oversize = 32'(hdr_len) > 32'(MAX_LEN);
    assign last     = (rem == LEN_W'(1));

    // Pop whenever the current state can absorb the head word.
    always_comb begin
        pop = 1'b0;
        if (!rst && !fifo_empty) begin
            unique case (state)
                HDR:     pop = 1'b1;
                DROP:    pop = 1'b1;
                PAYLOAD: pop = !m_valid || m_ready;
                default: pop = 1'b0;
            endcase
        end
    end

    assign fifo_rd_en = pop;
    assign load       = pop && (state == PAYLOAD);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= HDR;
        else     state <= state_nxt;
    end

    // Next-state: transitions only happen on a pop.
    always_comb begin
        state_nxt = state;
        if (pop) begin
            unique case (state)
                HDR: begin
                    if (oversize)          state_nxt = DROP;
                    else if (hdr_len != 0) state_nxt = PAYLOAD;
                end
                PAYLOAD: if (last) state_nxt = HDR;
                DROP:    if (last) state_nxt = HDR;
                default: state_nxt = HDR;
            endcase
        end
    end

    // Header capture, remaining-word count, counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            first   <= 1'b0;
            m_tag   <= '0;
            pkt_cnt <= '0;
            pkt_err <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            if (pop) begin
                unique case (state)
                    HDR: begin
                        if (oversize) begin
                            pkt_err <= 1'b1;
                            rem     <= hdr_len;
                        end else begin
                            pkt_cnt <= pkt_cnt + 32'd1;
                            m_tag   <= hdr_tag;
                            if (hdr_len != 0) begin
                                rem   <= hdr_len;
                                first <= 1'b1;
                            end
                        end
                    end
                    PAYLOAD: begin
                        first <= 1'b0;
                        rem   <= rem - 1'b1;
                    end
                    DROP:    rem <= rem - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    fwft_out_reg #(
        .DATA_W(DATA_W)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .ld_data (fifo_dout),
        .ld_sof  (first),
        .ld_eof  (last),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_sof   (m_sof),
        .m_eof   (m_eof)
    );

endmodule
